// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the data-memory stage: access-size encodings and
// the lane/legality decoder used by both the load and the store paths.
package data_mem_unit_pkg;

  localparam int unsigned DEPTH_LOG2_DEF = 10;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;

  typedef struct packed {
    logic [3:0] be;
    logic       legal;
  } lane_sel_t;

  // Byte-enable is forced to zero for illegal or misaligned accesses.
  function automatic lane_sel_t mem_lane_sel(input logic [2:0] op, input logic [1:0] lane);
    lane_sel_t s;
    s.be    = 4'b0000;
    s.legal = 1'b0;
    case (op)
      MEM_LB, MEM_LBU: begin
        s.be    = 4'b0001 << lane;
        s.legal = 1'b1;
      end
      MEM_LH, MEM_LHU: begin
        s.be    = lane[1] ? 4'b1100 : 4'b0011;
        s.legal = ~lane[0];
      end
      MEM_LW: begin
        s.be    = 4'b1111;
        s.legal = (lane == 2'b00);
      end
      default: ;
    endcase
    if (!s.legal) s.be = 4'b0000;
    return s;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised RAM with per-byte write enables and asynchronous read.
// Deliberately has no reset so contents survive a CPU reset.
module dmem_ram #(
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [2**AddrW];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: sized/extended loads, byte-enabled stores, alignment
// checking, sticky first-error capture and saturating access counters.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRd,
  input  logic             MemWr,
  input  logic [2:0]       MemOp,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WrData,
  output logic [31:0]      RdData,
  output logic             AddrErr,
  output logic             ErrFlag,
  output logic [31:0]      ErrAddr,
  output logic [CNT_W-1:0] LoadCnt,
  output logic [CNT_W-1:0] StoreCnt
);

  lane_sel_t       sel;
  logic [3:0]      ram_we;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic            sext;
  logic            err_flag_q;
  logic [31:0]     err_addr_q;
  logic [CNT_W-1:0] load_cnt_q;
  logic [CNT_W-1:0] store_cnt_q;
  logic            unused_addr;

  assign sel     = mem_lane_sel(MemOp, Addr[1:0]);
  assign AddrErr = (MemRd | MemWr) & ~sel.legal;

  // Upper address bits alias onto the RAM.
  assign unused_addr = ^Addr[31:DEPTH_LOG2+2];

  // Right-aligned store data is replicated so every lane sees its slice.
  always_comb begin
    ram_wdata = WrData;
    case (MemOp[1:0])
      2'b00:   ram_wdata = {4{WrData[7:0]}};
      2'b01:   ram_wdata = {2{WrData[15:0]}};
      default: ram_wdata = WrData;
    endcase
  end

  assign ram_we = (MemWr && !rst) ? sel.be : 4'b0000;

  dmem_ram #(
    .AddrW (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (Addr[DEPTH_LOG2+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign lane_byte = ram_rdata[{Addr[1:0], 3'b000} +: 8];
  assign lane_half = Addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
  assign sext      = ~MemOp[2];

  always_comb begin
    RdData = '0;
    if (MemRd && !AddrErr) begin
      case (MemOp[1:0])
        2'b00:   RdData = {{24{sext & lane_byte[7]}}, lane_byte};
        2'b01:   RdData = {{16{sext & lane_half[15]}}, lane_half};
        2'b10:   RdData = ram_rdata;
        default: RdData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      if (AddrErr && !err_flag_q) begin
        err_flag_q <= 1'b1;
        err_addr_q <= Addr;
      end
      if (MemRd && !AddrErr && (load_cnt_q != {CNT_W{1'b1}})) begin
        load_cnt_q <= load_cnt_q + 1'b1;
      end
      if (MemWr && !AddrErr && (store_cnt_q != {CNT_W{1'b1}})) begin
        store_cnt_q <= store_cnt_q + 1'b1;
      end
    end
  end

  assign ErrFlag  = err_flag_q;
  assign ErrAddr  = err_addr_q;
  assign LoadCnt  = load_cnt_q;
  assign StoreCnt = store_cnt_q;

endmodule
